harris_response: RTL and testbench
==================================

Name: harris_response

Overview:
- Pipelined Harris corner-response stage; sits directly downstream of the gradient stage in the harrisDetector datapath.
- Consumes one 4x4 Gx/Gy gradient window per valid cycle.
- Forms the structure tensor sums, computes R = det(M) - k*trace(M)^2 with k = 2^-K_SHIFT, and saturates R to 32 bits to drive harris_score.
- Also flags corners against a threshold and keeps a per-frame corner count.

Parameters:
- K_SHIFT, 4, k = 1/2^K_SHIFT (4 gives k = 0.0625).
- THRESH, 1000, signed 32-bit corner threshold; is_corner when score > THRESH.
- CNT_W, 16, corner_count width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- grad_valid  in  1  Gx_flat/Gy_flat hold a valid window this cycle.
- Gx_flat  in  256  16 signed 16-bit values; element (r,c) at bits [(r*4+c)*16 +: 16].
- Gy_flat  in  256  same layout as Gx_flat.
- frame_start  in  1  synchronous clear of corner_count.
- score_valid  out  1  score/is_corner are new this cycle.
- harris_score  out  32  signed saturated R.
- is_corner  out  1  harris_score > THRESH.
- corner_count  out  CNT_W  corners since last frame_start, saturating.

Behaviour:
- Reset (reset=0, async): all pipeline valid bits, data registers and outputs go to 0.
  - Windows in flight are discarded and nothing is emitted for them after release.
- Pipeline is fixed at 4 stages, throughput 1 window/cycle, no backpressure.
  - grad_valid sampled at edge n gives score_valid=1 after edge n+4.
  - Bubbles propagate as valid=0.
- S1: register per-element products gx*gx, gy*gy, gx*gy (signed, 32-bit), 48 products.
- S2: 16-term sums Sxx, Syy, Sxy, each 37-bit signed, computed exactly (no overflow possible).
- S3:
  - det = Sxx*Syy - Sxy*Sxy (74-bit signed).
  - tr = Sxx + Syy (38-bit).
  - tr2 = tr*tr (76-bit signed).
- S4:
  - R = det - (tr2 >>> K_SHIFT), arithmetic shift (floor).
  - Saturate: R > 2^31-1 gives 0x7FFFFFFF; R < -2^31 gives 0x80000000.
  - is_corner = (saturated R > THRESH), signed compare.
- Outputs:
  - harris_score and is_corner update only on cycles with S4 valid; otherwise they hold their last value.
  - score_valid is a 1-cycle pulse per window.
- Stage registers may be enabled by their valid bit; only the valid bits are required to be reset.
- corner_count:
  - Increments when score_valid && is_corner; saturates at all-ones (no wrap).
  - frame_start=1 clears it to 0, and clear takes priority over increment.
  - frame_start and a qualifying output in the same cycle give count 1, not 0.
  - Exception: if CNT_W saturation applies, see above; result is still 1.
- No internal state is shared between windows; each window's result depends only on its own inputs.

Test Plan:
- Zero window: Gx=Gy=0, one grad_valid pulse -> 4 cycles later score_valid=1, harris_score=0, is_corner=0; score_valid=0 on all other cycles.
- Edge: Gx=1 everywhere, Gy=0 -> Sxx=16, det=0, tr2=256 -> harris_score=0xFFFFFFF0 (-16), is_corner=0.
- Corner: Gx=10 where c<2 else 0, Gy=10 where c>=2 else 0 -> Sxx=Syy=800, Sxy=0, det=640000, tr2>>>4=160000 -> harris_score=480000, is_corner=1, corner_count 0->1.
- Saturation, two cases:
  - Gx=32767 all, Gy=-32768 all -> det=0, huge tr2 -> 0x80000000.
  - Gx=32767 on c<2, Gy=32767 on c>=2 -> 0x7FFFFFFF, is_corner=1.
- Streaming: corner, edge and zero vectors on 3 consecutive cycles, then a 1-cycle bubble, then corner -> results 480000, -16, 0 on consecutive cycles, one idle cycle, then 480000.
  - corner_count ends at 2.
  - frame_start coincident with the last output gives corner_count=1.
- Reset mid-flight: 2 windows in flight, pull reset low for 1 cycle -> all outputs 0 immediately and no score_valid afterwards.
  - Next window after release returns with normal 4-cycle latency.

Source files
------------

// File: rtl/harris_response_if.sv
// rtl/harris_response_if.sv - gradient-window input / Harris score output bus
interface harris_response_if #(
   parameter int CNT_W = 16
);
   logic               grad_valid;
   logic [255:0]       Gx_flat;
   logic [255:0]       Gy_flat;
   logic               frame_start;
   logic               score_valid;
   logic signed [31:0] harris_score;
   logic               is_corner;
   logic [CNT_W-1:0]   corner_count;

   modport master (output grad_valid, Gx_flat, Gy_flat, frame_start,
                   input  score_valid, harris_score, is_corner, corner_count);
   modport slave  (input  grad_valid, Gx_flat, Gy_flat, frame_start,
                   output score_valid, harris_score, is_corner, corner_count);
endinterface

// File: rtl/harris_response.sv
// rtl/harris_response.sv - 4-stage Harris corner response, threshold flag and frame corner count
module harris_response #(
   parameter int                 K_SHIFT = 4,
   parameter logic signed [31:0] THRESH  = 32'sd1000,
   parameter int                 CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   harris_response_if.slave bus
);
   localparam logic signed [76:0] R_MAX = 77'sd2147483647;
   localparam logic signed [76:0] R_MIN = -77'sd2147483648;

   logic               v1, v2, v3, v4;
   logic signed [31:0] p_xx [16];
   logic signed [31:0] p_yy [16];
   logic signed [31:0] p_xy [16];
   logic signed [36:0] sxx, syy, sxy;
   logic signed [36:0] sxx_c, syy_c, sxy_c;
   logic signed [37:0] tr_c;
   logic signed [73:0] det, det_c;
   logic signed [75:0] tr2, tr2_c;
   logic signed [76:0] r, r_c;
   logic signed [31:0] sat_c;
   logic               corner_c;

   function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
      return 32'(a) * 32'(b);
   endfunction

   // S1: per-element tensor products of the incoming window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1 <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            p_xx[i] <= '0;
            p_yy[i] <= '0;
            p_xy[i] <= '0;
         end
      end else begin
         v1 <= bus.grad_valid;
         if (bus.grad_valid) begin
            for (int i = 0; i < 16; i++) begin
               p_xx[i] <= mul16(bus.Gx_flat[i*16 +: 16], bus.Gx_flat[i*16 +: 16]);
               p_yy[i] <= mul16(bus.Gy_flat[i*16 +: 16], bus.Gy_flat[i*16 +: 16]);
               p_xy[i] <= mul16(bus.Gx_flat[i*16 +: 16], bus.Gy_flat[i*16 +: 16]);
            end
         end
      end
   end

   // 16-term sums; 37 bits holds 16 * 2^30 exactly
   always_comb begin
      sxx_c = '0;
      syy_c = '0;
      sxy_c = '0;
      for (int i = 0; i < 16; i++) begin
         sxx_c = sxx_c + 37'(p_xx[i]);
         syy_c = syy_c + 37'(p_yy[i]);
         sxy_c = sxy_c + 37'(p_xy[i]);
      end
   end

   // S2: register structure tensor sums
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2  <= 1'b0;
         sxx <= '0;
         syy <= '0;
         sxy <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            sxx <= sxx_c;
            syy <= syy_c;
            sxy <= sxy_c;
         end
      end
   end

   // determinant and squared trace at full precision
   always_comb begin
      tr_c  = 38'(sxx) + 38'(syy);
      det_c = 74'(sxx) * 74'(syy) - 74'(sxy) * 74'(sxy);
      tr2_c = 76'(tr_c) * 76'(tr_c);
   end

   // S3: register det and tr^2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v3  <= 1'b0;
         det <= '0;
         tr2 <= '0;
      end else begin
         v3 <= v2;
         if (v2) begin
            det <= det_c;
            tr2 <= tr2_c;
         end
      end
   end

   // k * tr^2 with k = 2^-K_SHIFT is a flooring arithmetic shift
   assign r_c = 77'(det) - 77'(tr2 >>> K_SHIFT);

   // S4: register unsaturated response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v4 <= 1'b0;
         r  <= '0;
      end else begin
         v4 <= v3;
         if (v3) r <= r_c;
      end
   end

   // clamp to signed 32 bits and compare against the threshold
   always_comb begin
      if (r > R_MAX)      sat_c = 32'sh7FFF_FFFF;
      else if (r < R_MIN) sat_c = 32'sh8000_0000;
      else                sat_c = r[31:0];
      corner_c = sat_c > THRESH;
   end

   // output registers hold their value between valid results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.score_valid  <= 1'b0;
         bus.harris_score <= '0;
         bus.is_corner    <= 1'b0;
      end else begin
         bus.score_valid <= v4;
         if (v4) begin
            bus.harris_score <= sat_c;
            bus.is_corner    <= corner_c;
         end
      end
   end

   // frame corner count; a clear still counts a coincident corner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.corner_count <= '0;
      end else if (bus.frame_start) begin
         bus.corner_count <= (bus.score_valid && bus.is_corner) ? CNT_W'(1) : '0;
      end else if (bus.score_valid && bus.is_corner && bus.corner_count != {CNT_W{1'b1}}) begin
         bus.corner_count <= bus.corner_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_harris_response.sv
// tb/tb_harris_response.sv - self-checking bench for harris_response
module tb_harris_response;
   localparam int K_SHIFT = 4;
   localparam int THRESH  = 1000;
   localparam int CNT_W   = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   harris_response_if #(.CNT_W(CNT_W)) bus ();

   harris_response #(
      .K_SHIFT(K_SHIFT),
      .THRESH (32'sd1000),
      .CNT_W  (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int          due;
      logic [31:0] score;
      logic        corner;
   } exp_t;

   exp_t              q[$];
   int                cyc        = 0;
   int                tests      = 0;
   int                fails      = 0;
   logic              exp_sv     = 1'b0;
   logic [31:0]       exp_score  = '0;
   logic              exp_corner = 1'b0;
   int                exp_cnt    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, want);
      end
   endtask

   function automatic logic [255:0] fill(input int left, input int right);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = ((i % 4) < 2) ? 16'(left) : 16'(right);
      return v;
   endfunction

   function automatic void ref_score(input logic [255:0] gx, input logic [255:0] gy,
                                     output logic [31:0] sc, output logic cn);
      longint sxx, syy, sxy;
      logic signed [127:0] det, tr2, rr;
      sxx = 0; syy = 0; sxy = 0;
      for (int i = 0; i < 16; i++) begin
         longint a, b;
         a = longint'($signed(gx[i*16 +: 16]));
         b = longint'($signed(gy[i*16 +: 16]));
         sxx += a * a;
         syy += b * b;
         sxy += a * b;
      end
      det = 128'(sxx) * 128'(syy) - 128'(sxy) * 128'(sxy);
      tr2 = (128'(sxx) + 128'(syy)) * (128'(sxx) + 128'(syy));
      rr  = det - tr2 / (128'sd1 <<< K_SHIFT);
      if (rr > 128'sd2147483647)       sc = 32'h7FFF_FFFF;
      else if (rr < -128'sd2147483648) sc = 32'h8000_0000;
      else                             sc = rr[31:0];
      cn = $signed(sc) > THRESH;
   endfunction

   task automatic check_outputs();
      chk("score_valid",  32'(bus.score_valid),  32'(exp_sv));
      chk("harris_score", bus.harris_score,      exp_score);
      chk("is_corner",    32'(bus.is_corner),    32'(exp_corner));
      chk("corner_count", 32'(bus.corner_count), 32'(exp_cnt));
   endtask

   task automatic tick();
      int n;
      n = bus.frame_start ? 0 : exp_cnt;
      if (exp_sv && exp_corner) n++;
      if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
      if (reset) exp_cnt = n;
      @(posedge clk);
      cyc++;
      #1;
      if (reset && q.size() > 0 && q[0].due == cyc) begin
         exp_sv     = 1'b1;
         exp_score  = q[0].score;
         exp_corner = q[0].corner;
         void'(q.pop_front());
      end else begin
         exp_sv = 1'b0;
      end
      check_outputs();
   endtask

   task automatic drive(input logic [255:0] gx, input logic [255:0] gy,
                        input logic [31:0] sc, input logic cn);
      bus.Gx_flat    = gx;
      bus.Gy_flat    = gy;
      bus.grad_valid = 1'b1;
      q.push_back('{due: cyc + 5, score: sc, corner: cn});
      tick();
      bus.grad_valid = 1'b0;
   endtask

   function automatic logic [255:0] rand_win(input int mode);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) begin
         case (mode)
            0:       v[i*16 +: 16] = 16'(int'($urandom_range(0, 40)) - 20);
            1:       v[i*16 +: 16] = 16'(int'($urandom_range(0, 600)) - 300);
            default: v[i*16 +: 16] = 16'($urandom_range(0, 65535));
         endcase
      end
      return v;
   endfunction

   initial begin
      logic [255:0] gx, gy;
      logic [31:0]  sc;
      logic         cn;
      int           mode;

      reset           = 1'b0;
      bus.grad_valid  = 1'b0;
      bus.Gx_flat     = '0;
      bus.Gy_flat     = '0;
      bus.frame_start = 1'b0;

      // reset state
      tick();
      tick();
      reset = 1'b1;
      tick();

      // zero, edge, corner windows in isolation
      drive(fill(0, 0), fill(0, 0), 32'd0, 1'b0);
      repeat (6) tick();
      drive(fill(1, 1), fill(0, 0), 32'hFFFF_FFF0, 1'b0);
      repeat (6) tick();
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      repeat (6) tick();
      chk("count_after_corner", 32'(bus.corner_count), 32'd1);

      // saturation both ways
      drive(fill(32767, 32767), fill(-32768, -32768), 32'h8000_0000, 1'b0);
      repeat (6) tick();
      drive(fill(32767, 0), fill(0, 32767), 32'h7FFF_FFFF, 1'b1);
      repeat (6) tick();

      // streaming with a bubble after a frame clear
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      drive(fill(1, 1), fill(0, 0), 32'hFFFF_FFF0, 1'b0);
      drive(fill(0, 0), fill(0, 0), 32'd0, 1'b0);
      tick();
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      repeat (6) tick();
      chk("stream_count", 32'(bus.corner_count), 32'd2);

      // same stream, frame_start coincident with the last output
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      drive(fill(1, 1), fill(0, 0), 32'hFFFF_FFF0, 1'b0);
      drive(fill(0, 0), fill(0, 0), 32'd0, 1'b0);
      tick();
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      repeat (4) tick();
      chk("last_out_visible", 32'(bus.score_valid), 32'd1);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("clear_with_corner", 32'(bus.corner_count), 32'd1);

      // reset with two windows in flight
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      reset = 1'b0;
      #1;
      q.delete();
      exp_sv     = 1'b0;
      exp_score  = '0;
      exp_corner = 1'b0;
      exp_cnt    = 0;
      check_outputs();
      tick();
      reset = 1'b1;
      repeat (8) tick();
      drive(fill(10, 0), fill(0, 10), 32'd480000, 1'b1);
      repeat (6) tick();

      // randomized windows against the reference model
      for (int it = 0; it < 60; it++) begin
         mode = int'($urandom_range(0, 2));
         gx   = rand_win(mode);
         gy   = rand_win(mode);
         ref_score(gx, gy, sc, cn);
         bus.frame_start = ($urandom_range(0, 7) == 0);
         drive(gx, gy, sc, cn);
         bus.frame_start = 1'b0;
         if ($urandom_range(0, 3) == 0) tick();
      end
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
